// File: rtl/pwm_pkg.sv
// Register map and status layout shared by the PWM bank and its helpers.
package pwm_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_CHEN   = 1;
  localparam int unsigned REG_PRESC  = 2;
  localparam int unsigned REG_PERIOD = 3;
  localparam int unsigned REG_DUTY0  = 4;

  localparam int unsigned ST_RUN  = 0;
  localparam int unsigned ST_CNT  = 1;
  localparam int unsigned ST_WRAP = 2;
  localparam int unsigned ST_OUT  = 3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_POL_LSB = 4;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running prescaler: tick whenever the count has reached the (live) divider value.
module pwm_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic [WIDTH-1:0] presc,
  output logic             tick
);

  logic [WIDTH-1:0] presc_cnt_q, presc_cnt_d;

  // >= rather than == so a divider lowered below the count still ticks next cycle
  assign tick = (presc_cnt_q >= presc);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (ena) begin
      if (clear || tick) presc_cnt_d = '0;
      else               presc_cnt_d = presc_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_cnt_q <= '0;
    else     presc_cnt_q <= presc_cnt_d;
  end

endmodule

// File: rtl/pwm_bank.sv
// Register-driven multi-channel PWM with double-buffered period/duty/polarity/enable.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [NUM_REGS*WIDTH-1:0] config_regs,
  output logic [NUM_REGS*WIDTH-1:0] status_regs,
  output logic [NUM_CH-1:0]         pwm_out
);

  if (NUM_REGS != 8 || NUM_CH > NUM_REGS - 4 || NUM_CH > 4) begin : g_param_check
    $error("pwm_bank: NUM_REGS must be 8 and NUM_CH must fit in the duty registers");
  end

  logic                    en_cfg;
  logic [NUM_CH-1:0]       pol_cfg, chen_cfg;
  logic [WIDTH-1:0]        presc_cfg, period_cfg;
  logic [NUM_CH-1:0][WIDTH-1:0] duty_cfg;
  logic                    unused_cfg;

  logic [WIDTH-1:0]        cnt_q, cnt_d, wrap_q, wrap_d;
  logic [WIDTH-1:0]        period_sh_q, period_sh_d;
  logic [NUM_CH-1:0][WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0]       pol_sh_q, pol_sh_d, chen_sh_q, chen_sh_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic [NUM_REGS*WIDTH-1:0] status_q, status_d;
  logic                    tick;
  logic                    load_sh;

  // Config field decode; reserved bits are deliberately ignored
  always_comb begin
    en_cfg     = config_regs[REG_CTRL*WIDTH + CTRL_EN];
    pol_cfg    = config_regs[REG_CTRL*WIDTH + CTRL_POL_LSB +: NUM_CH];
    chen_cfg   = config_regs[REG_CHEN*WIDTH +: NUM_CH];
    presc_cfg  = config_regs[REG_PRESC*WIDTH +: WIDTH];
    period_cfg = config_regs[REG_PERIOD*WIDTH +: WIDTH];
    for (int i = 0; i < int'(NUM_CH); i++) begin
      duty_cfg[i] = config_regs[(REG_DUTY0 + i)*WIDTH +: WIDTH];
    end
  end
  assign unused_cfg = ^config_regs;

  pwm_prescaler #(.WIDTH(WIDTH)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clear (~en_cfg),
    .presc (presc_cfg),
    .tick  (tick)
  );

  // Period counter, shadow reload and output compare
  always_comb begin
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pol_sh_d    = pol_sh_q;
    chen_sh_d   = chen_sh_q;
    pwm_d       = pwm_q;
    load_sh     = 1'b0;

    if (ena) begin
      if (!en_cfg) begin
        cnt_d   = '0;
        pwm_d   = pol_cfg;
        load_sh = 1'b1;
      end else begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          pwm_d[i] = (chen_sh_q[i] & (cnt_q < duty_sh_q[i])) ^ pol_sh_q[i];
        end
        if (tick) begin
          if (cnt_q == period_sh_q) begin
            cnt_d   = '0;
            wrap_d  = wrap_q + WIDTH'(1);
            load_sh = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
    end

    if (load_sh) begin
      period_sh_d = period_cfg;
      duty_sh_d   = duty_cfg;
      pol_sh_d    = pol_cfg;
      chen_sh_d   = chen_cfg;
    end
  end

  // Status mirrors internal state one clock late; the run bit also drops while frozen
  always_comb begin
    status_d = '0;
    status_d[ST_RUN*WIDTH]            = en_cfg & ena;
    status_d[ST_CNT*WIDTH +: WIDTH]   = cnt_q;
    status_d[ST_WRAP*WIDTH +: WIDTH]  = wrap_q;
    status_d[ST_OUT*WIDTH +: NUM_CH]  = pwm_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      wrap_q      <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      pol_sh_q    <= '0;
      chen_sh_q   <= '0;
      pwm_q       <= '0;
      status_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pol_sh_q    <= pol_sh_d;
      chen_sh_q   <= chen_sh_d;
      pwm_q       <= pwm_d;
      status_q    <= status_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign status_regs = status_q;

endmodule
